// File: rtl/bram_responder.sv
// bram_responder: memory-side responder for a single-port synchronous BRAM bus.
//
// Storage is a word-addressed array with a configurable read pipeline and a
// selectable read-during-write policy. It also provides a read-valid strobe,
// a sticky out-of-range error flag and saturating access counters.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   bram_addr      word address
//   bram_en        access enable
//   bram_we        write enable, qualified by bram_en
//   bram_data_in   write data
//   bram_data_out  read data (registered)
//   rd_valid_o     one-cycle pulse aligned with each read result
//   err_o          sticky out-of-range flag
//   err_clr_i      synchronous clear of err_o (a same-edge error wins)
//   rd_count_o     saturating count of in-range reads
//   wr_count_o     saturating count of in-range writes

module bram_responder #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 8192,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned RDW_MODE      = 0,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] bram_addr,
    input  logic                     bram_en,
    input  logic                     bram_we,
    input  logic [DATA_WIDTH-1:0]    bram_data_in,
    output logic [DATA_WIDTH-1:0]    bram_data_out,
    output logic                     rd_valid_o,
    output logic                     err_o,
    input  logic                     err_clr_i,
    output logic [COUNT_WIDTH-1:0]   rd_count_o,
    output logic [COUNT_WIDTH-1:0]   wr_count_o
);

    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NumStages = READ_LATENCY;

    // One extra bit so DEPTH == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] DepthVal = (ADDRESS_WIDTH + 1)'(DEPTH);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            in_range;
    logic            rd_req;
    logic            wr_req;
    logic [IdxW-1:0] idx;

    assign in_range = ({1'b0, bram_addr} < DepthVal);
    assign rd_req   = bram_en & ~bram_we;
    assign wr_req   = bram_en & bram_we;
    assign idx      = bram_addr[IdxW-1:0];

    // ------------------------------------------------------------------
    // Storage array (no reset so it maps onto block RAM)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign mem_rdata = mem[idx];

    always_ff @(posedge clk_i) begin
        if (wr_req && in_range) begin
            mem[idx] <= bram_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // Each stage holds a data word, a valid bit (real read result) and a
    // launch bit (stage data was refreshed this cycle). Data only moves
    // into a stage when a launch arrives, so the output holds its last
    // value through idle cycles. Writes launch without a valid bit.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q [NumStages];
    logic [NumStages-1:0]  launch_q;
    logic [NumStages-1:0]  valid_q;

    logic [DATA_WIDTH-1:0] head_data_d;
    logic                  head_launch_d;
    logic                  head_valid_d;

    always_comb begin
        head_data_d   = data_q[0];
        head_launch_d = 1'b0;
        head_valid_d  = 1'b0;
        if (rd_req) begin
            head_launch_d = 1'b1;
            head_valid_d  = 1'b1;
            // Out-of-range reads still return a (zero) result on time.
            head_data_d   = in_range ? mem_rdata : '0;
        end else if (wr_req && in_range) begin
            head_launch_d = 1'b1;
            if (RDW_MODE == 0) begin
                head_data_d = mem_rdata;
            end else if (RDW_MODE == 1) begin
                head_data_d = bram_data_in;
            end
            // No-change mode keeps the stage contents.
        end
    end

    for (genvar g = 0; g < NumStages; g++) begin : gen_stage
        if (g == 0) begin : gen_head
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_q[0]   <= '0;
                    launch_q[0] <= 1'b0;
                    valid_q[0]  <= 1'b0;
                end else begin
                    data_q[0]   <= head_data_d;
                    launch_q[0] <= head_launch_d;
                    valid_q[0]  <= head_valid_d;
                end
            end
        end else begin : gen_tail
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_q[g]   <= '0;
                    launch_q[g] <= 1'b0;
                    valid_q[g]  <= 1'b0;
                end else begin
                    if (launch_q[g-1]) begin
                        data_q[g] <= data_q[g-1];
                    end
                    launch_q[g] <= launch_q[g-1];
                    valid_q[g]  <= valid_q[g-1];
                end
            end
        end
    end

    // The launch bit of the final stage has no consumer.
    logic unused_launch;
    assign unused_launch = launch_q[NumStages-1];

    assign bram_data_out = data_q[NumStages-1];
    assign rd_valid_o    = valid_q[NumStages-1];

    // ------------------------------------------------------------------
    // Error flag and access counters
    // ------------------------------------------------------------------
    logic                   err_q;
    logic                   err_d;
    logic [COUNT_WIDTH-1:0] rd_count_q;
    logic [COUNT_WIDTH-1:0] rd_count_d;
    logic [COUNT_WIDTH-1:0] wr_count_q;
    logic [COUNT_WIDTH-1:0] wr_count_d;

    always_comb begin
        err_d      = err_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;

        // Set has priority over a same-edge clear.
        if (bram_en && !in_range) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end

        if (rd_req && in_range && (rd_count_q != CountMax)) begin
            rd_count_d = rd_count_q + CountOne;
        end
        if (wr_req && in_range && (wr_count_q != CountMax)) begin
            wr_count_d = wr_count_q + CountOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign err_o      = err_q;
    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_bram_responder.sv
// Bench for bram_responder. Three instances share one stimulus stream:
//   u0: latency 1, read-first,   4-bit counters
//   u1: latency 3, write-first, 16-bit counters
//   u2: latency 1, no-change,   16-bit counters
// All use DEPTH 4096 with a 13-bit address so the upper half is out of range.
// Read results are predicted into per-instance queues (data + arrival cycle)
// and popped when the instance raises rd_valid_o.

module tb_bram_responder;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [DW-1:0] din;
    logic          clr;

    logic [DW-1:0] dout [3];
    logic          vld  [3];
    logic          err  [3];
    logic [15:0]   rdc  [3];
    logic [15:0]   wrc  [3];
    logic [3:0]    rdc0;
    logic [3:0]    wrc0;

    assign rdc[0] = {12'h0, rdc0};
    assign wrc[0] = {12'h0, wrc0};

    always #5 clk = ~clk;

    bram_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096),
        .READ_LATENCY(1), .RDW_MODE(0), .COUNT_WIDTH(4)
    ) u0 (
        .clk_i(clk), .rst_i(rst_n), .bram_addr(addr), .bram_en(en), .bram_we(we),
        .bram_data_in(din), .bram_data_out(dout[0]), .rd_valid_o(vld[0]), .err_o(err[0]),
        .err_clr_i(clr), .rd_count_o(rdc0), .wr_count_o(wrc0)
    );

    bram_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096),
        .READ_LATENCY(3), .RDW_MODE(1), .COUNT_WIDTH(16)
    ) u1 (
        .clk_i(clk), .rst_i(rst_n), .bram_addr(addr), .bram_en(en), .bram_we(we),
        .bram_data_in(din), .bram_data_out(dout[1]), .rd_valid_o(vld[1]), .err_o(err[1]),
        .err_clr_i(clr), .rd_count_o(rdc[1]), .wr_count_o(wrc[1])
    );

    bram_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096),
        .READ_LATENCY(1), .RDW_MODE(2), .COUNT_WIDTH(16)
    ) u2 (
        .clk_i(clk), .rst_i(rst_n), .bram_addr(addr), .bram_en(en), .bram_we(we),
        .bram_data_in(din), .bram_data_out(dout[2]), .rd_valid_o(vld[2]), .err_o(err[2]),
        .err_clr_i(clr), .rd_count_o(rdc[2]), .wr_count_o(wrc[2])
    );

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t         exp_q [3][$];
    int          lat   [3] = '{1, 3, 1};
    int          maxc  [3] = '{15, 65535, 65535};
    int          exp_rd[3];
    int          exp_wr[3];
    bit          exp_err;
    logic [31:0] mm [4096];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare each read result as the instance produces it.
    always @(negedge clk) begin : monitor
        ev_t e;
        for (int k = 0; k < 3; k++) begin
            if (vld[k] === 1'b1) begin
                n_checks++;
                if (exp_q[k].size() == 0) begin
                    $display("FAIL rd_pulse u%0d: unexpected pulse data=%h at cycle %0d, want none",
                             k, dout[k], cyc);
                end else begin
                    e = exp_q[k].pop_front();
                    if (dout[k] !== e.data || cyc != e.cyc) begin
                        $display("FAIL rd_data u%0d: got %h at cycle %0d, want %h at cycle %0d",
                                 k, dout[k], cyc, e.data, e.cyc);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    // Drive one request for the next edge and update the model.
    task automatic drive(input bit e, input bit w, input logic [AW-1:0] a,
                         input logic [31:0] d, input bit c);
        bit inr;
        inr  = (a < 13'h1000);
        en   = e;
        we   = w;
        addr = a;
        din  = d;
        clr  = c;
        for (int k = 0; k < 3; k++) begin
            if (e && !w) exp_q[k].push_back('{inr ? mm[a[11:0]] : 32'h0, cyc + lat[k]});
            if (e && inr && !w && exp_rd[k] < maxc[k]) exp_rd[k]++;
            if (e && inr && w && exp_wr[k] < maxc[k]) exp_wr[k]++;
        end
        if (e && !inr) exp_err = 1'b1;
        else if (c) exp_err = 1'b0;
        if (e && w && inr) mm[a[11:0]] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en  = 1'b0;
        we  = 1'b0;
        clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== 32'h0 || vld[k] !== 1'b0 || err[k] !== 1'b0 ||
                rdc[k] !== 16'h0 || wrc[k] !== 16'h0) begin
                $display("FAIL reset u%0d: got dout=%h vld=%b err=%b rd=%0d wr=%0d, want all 0",
                         k, dout[k], vld[k], err[k], rdc[k], wrc[k]);
            end else n_pass++;
        end
    endtask

    task automatic test_basic();
        drive(1, 1, 13'h0005, 32'hDEADBEEF, 0);
        drive(1, 0, 13'h0005, 32'h0, 0);
        idle(5);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdc[k] !== 16'd1 || wrc[k] !== 16'd1) begin
                $display("FAIL basic_counts u%0d: got rd=%0d wr=%0d, want rd=1 wr=1",
                         k, rdc[k], wrc[k]);
            end else n_pass++;
            n_checks++;
            if (exp_q[k].size() != 0) begin
                $display("FAIL basic_pending u%0d: got %0d reads outstanding, want 0",
                         k, exp_q[k].size());
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) drive(1, 1, AW'(i), 32'h100 + i, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, AW'(i), 32'h0, 0);
        idle(6);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (exp_q[k].size() != 0 || dout[k] !== 32'h107) begin
                $display("FAIL stream u%0d: got %0d outstanding last=%h, want 0 outstanding last=107",
                         k, exp_q[k].size(), dout[k]);
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    task automatic test_rdw();
        drive(1, 1, 13'h0010, 32'hAAAA0000, 0);
        drive(1, 1, 13'h0011, 32'h12345678, 0);
        drive(1, 0, 13'h0010, 32'h0, 0);
        drive(1, 0, 13'h0011, 32'h0, 0);
        drive(1, 1, 13'h0010, 32'h5555FFFF, 0);
        en = 1'b0;
        we = 1'b0;
        n_checks++;
        if (dout[0] !== 32'hAAAA0000 || vld[0] !== 1'b0) begin
            $display("FAIL rdw_read_first: got %h vld=%b, want aaaa0000 vld=0", dout[0], vld[0]);
        end else n_pass++;
        n_checks++;
        if (dout[2] !== 32'h12345678 || vld[2] !== 1'b0) begin
            $display("FAIL rdw_no_change: got %h vld=%b, want 12345678 vld=0", dout[2], vld[2]);
        end else n_pass++;
        idle(2);
        n_checks++;
        if (dout[1] !== 32'h5555FFFF || vld[1] !== 1'b0) begin
            $display("FAIL rdw_write_first: got %h vld=%b, want 5555ffff vld=0", dout[1], vld[1]);
        end else n_pass++;
        n_checks++;
        if (dout[0] !== 32'hAAAA0000) begin
            $display("FAIL rdw_hold: got %h, want aaaa0000", dout[0]);
        end else n_pass++;
        idle(3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (exp_q[k].size() != 0) begin
                $display("FAIL rdw_pending u%0d: got %0d outstanding, want 0", k, exp_q[k].size());
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 13'h0FFF, 32'hCAFEF00D, 0);
        drive(1, 0, 13'h1000, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (err[k] !== exp_err) begin
                $display("FAIL oor_err_set u%0d: got %b, want %b", k, err[k], exp_err);
            end else n_pass++;
        end
        drive(1, 1, 13'h1FFF, 32'h0BADBEEF, 0);
        drive(1, 0, 13'h0FFF, 32'h0, 0);
        drive(1, 0, 13'h1234, 32'h0, 1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (err[k] !== 1'b1) begin
                $display("FAIL oor_set_wins u%0d: got %b, want 1", k, err[k]);
            end else n_pass++;
        end
        drive(0, 0, 13'h0, 32'h0, 1);
        idle(5);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (err[k] !== 1'b0) begin
                $display("FAIL oor_clear u%0d: got %b, want 0", k, err[k]);
            end else n_pass++;
            n_checks++;
            if (rdc[k] !== exp_rd[k][15:0] || wrc[k] !== exp_wr[k][15:0]) begin
                $display("FAIL oor_counts u%0d: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
                         k, rdc[k], wrc[k], exp_rd[k], exp_wr[k]);
            end else n_pass++;
            n_checks++;
            if (exp_q[k].size() != 0) begin
                $display("FAIL oor_pending u%0d: got %0d outstanding, want 0", k, exp_q[k].size());
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 13'h0005, 32'h0, 0);
        drive(1, 0, 13'h0006, 32'h0, 0);
        // The second read never completes; the first only where latency is 1
        // (already consumed by the scoreboard there).
        for (int k = 0; k < 3; k++) begin
            void'(exp_q[k].pop_back());
            if (lat[k] > 1) void'(exp_q[k].pop_back());
        end
        rst_n = 1'b0;
        en    = 1'b0;
        we    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 0;
            exp_wr[k] = 0;
        end
        exp_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== 32'h0 || vld[k] !== 1'b0 || rdc[k] !== 16'h0 || wrc[k] !== 16'h0) begin
                $display("FAIL reset_mid u%0d: got dout=%h vld=%b rd=%0d wr=%0d, want all 0",
                         k, dout[k], vld[k], rdc[k], wrc[k]);
            end else n_pass++;
        end
        idle(5);
        drive(1, 0, 13'h0005, 32'h0, 0);
        drive(1, 0, 13'h0006, 32'h0, 0);
        idle(5);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (exp_q[k].size() != 0 || rdc[k] !== 16'd2) begin
                $display("FAIL reset_mid_readback u%0d: got %0d outstanding rd=%0d, want 0 and 2",
                         k, exp_q[k].size(), rdc[k]);
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) drive(1, 0, 13'h0007, 32'h0, 0);
        idle(4);
        n_checks++;
        if (rdc[0] !== 16'hF || rdc[1] !== 16'd22) begin
            $display("FAIL sat_rd: got u0=%0d u1=%0d, want u0=15 u1=22", rdc[0], rdc[1]);
        end else n_pass++;
        drive(1, 0, 13'h0007, 32'h0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 13'h0020, 32'h300 + i, 0);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdc[k] !== exp_rd[k][15:0] || wrc[k] !== exp_wr[k][15:0]) begin
                $display("FAIL sat_hold u%0d: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
                         k, rdc[k], wrc[k], exp_rd[k], exp_wr[k]);
            end else n_pass++;
            n_checks++;
            if (exp_q[k].size() != 0) begin
                $display("FAIL sat_pending u%0d: got %0d outstanding, want 0", k, exp_q[k].size());
                exp_q[k].delete();
            end else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 0;
            exp_wr[k] = 0;
        end
        exp_err = 1'b0;
        test_reset();
        test_basic();
        test_streaming();
        test_rdw();
        test_out_of_range();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Memory-side responder for the single-port BRAM bus that the BRAM controller drives (bram_addr, bram_en, bram_we, bram_data_in, bram_data_out).
- Provides the word-addressed storage array with a configurable read pipeline and a selectable read-during-write policy.
- Adds a read-valid strobe, a sticky out-of-range error flag, and saturating access counters for bring-up and verification.
- Sits directly under the controller in place of a vendor BRAM primitive; behaviour matches a synchronous BRAM port.

Parameters:
- ADDRESS_WIDTH, 13, word address width; must match the controller.
- DATA_WIDTH, 32, BRAM word width.
- DEPTH, 8192, number of implemented words; 1 <= DEPTH <= 2**ADDRESS_WIDTH.
- READ_LATENCY, 1, number of clock edges from request sample to data on the output; legal values are 1, 2 and 3.
- RDW_MODE, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change.
- COUNT_WIDTH, 16, width of each access counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- bram_addr  input  ADDRESS_WIDTH  word address.
- bram_en  input  1  access enable.
- bram_we  input  1  write enable; qualified by bram_en.
- bram_data_in  input  DATA_WIDTH  write data.
- bram_data_out  output  DATA_WIDTH  read data.
- rd_valid_o  output  1  one-cycle pulse, aligned with bram_data_out, for each read request.
- err_o  output  1  sticky flag for an out-of-range access.
- err_clr_i  input  1  synchronous clear of err_o.
- rd_count_o  output  COUNT_WIDTH  count of accepted reads, saturating.
- wr_count_o  output  COUNT_WIDTH  count of accepted writes, saturating.

Behaviour:
- Reset, with rst_i low and asynchronous:
  - bram_data_out, rd_valid_o, err_o and both counters go to 0.
  - All read-pipeline stages and their valid bits clear.
  - Memory contents are not reset.
- Reset mid-operation: in-flight reads are discarded, and no rd_valid_o pulse is produced after release.
- Request classes, sampled at each rising edge (edge N):
  - Idle: bram_en=0.
  - Read: bram_en=1, bram_we=0.
  - Write: bram_en=1, bram_we=1.
- In range means bram_addr < DEPTH.
- Write, in range:
  - mem[addr] <= bram_data_in at edge N.
  - wr_count_o increments.
  - A read launches into the pipeline with no valid bit set.
  - Pipeline data is: old mem[addr] for RDW_MODE 0; bram_data_in for RDW_MODE 1; nothing for RDW_MODE 2, where the stage holds its previous value.
- Read, in range:
  - mem[addr] is captured at edge N.
  - The data appears on bram_data_out after edge N+READ_LATENCY-1 and stays stable until the next launch reaches the output.
  - rd_valid_o is high for exactly that one cycle.
  - rd_count_o increments.
- Pipeline:
  - READ_LATENCY-1 extra register stages follow the array read register; each stage carries a data word and a valid bit.
  - Stages advance every cycle. Back-to-back reads give one result per cycle, in order.
  - If no launch reaches the output, bram_data_out holds its last value and rd_valid_o is 0.
- Out of range, bram_en=1 and bram_addr >= DEPTH:
  - The memory is not modified.
  - For a read, the result word is 0 and rd_valid_o still pulses at the normal latency.
  - The counters do not change.
  - err_o is set at edge N.
- err_o handling:
  - err_o clears at an edge where err_clr_i=1.
  - If err_clr_i and a new error occur at the same edge, the set wins and err_o stays 1.
- Counters saturate at all-ones; they never wrap.
- bram_we with bram_en=0 is ignored completely.
- There is no backpressure: every request is accepted in the cycle it is presented.
- Implementation:
  - The array is inferred as block RAM with one read/write port.
  - No combinational path from the inputs to the outputs.

Test Plan:
- Reset then write and read back, READ_LATENCY=1: after reset, write 0xDEADBEEF at address 0x0005, then read 0x0005 one cycle later -> bram_data_out=0xDEADBEEF with rd_valid_o=1 exactly one cycle after the read edge; rd_count_o=1, wr_count_o=1.
- Streaming reads, READ_LATENCY=3: write addresses 0..7 with values 0x100+i, then read 0..7 back-to-back -> eight consecutive rd_valid_o pulses, the first 3 edges after the first read, data 0x100..0x107 in order.
- Read-during-write: mem[0x10]=0xAAAA0000, then write 0x5555FFFF to 0x10 -> the output carries 0xAAAA0000 for RDW_MODE=0, 0x5555FFFF for RDW_MODE=1, and the previous value for RDW_MODE=2; rd_valid_o=0 in all three cases.
- Out of range, DEPTH=4096: read 0x1000 -> bram_data_out=0 with rd_valid_o pulsed, err_o=1, counters unchanged. Write 0x1FFF -> mem[0x0FFF] unchanged. Then assert err_clr_i together with a new out-of-range access -> err_o stays 1. Assert err_clr_i alone -> err_o returns to 0.
- Reset mid-read, READ_LATENCY=3: issue 2 reads, pull rst_i low one cycle later for 2 cycles -> no rd_valid_o afterwards, outputs are 0, and previously written memory data is still readable.
- Saturation, COUNT_WIDTH=4: 20 reads -> rd_count_o=0xF and holds at 0xF.
